alu_exec: RTL and testbench

//  Execute-stage ALU: consumes the 4-bit ALUControl from the ALU decoder plus operands.

---
 rtl/alu_exec.sv | 181 ++++++++++++++++++
 tb/tb_alu_exec.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with valid/ready on both sides.
// Result, zero flag and destination tag are registered toward the memory stage.
// Non-shift ops complete in one cycle. Shifts run serially, one bit per cycle,
// unless FAST_SHIFT_EN is defined, which selects a single-cycle barrel shifter
// and removes the SHIFT state (busy is then tied low).
module alu_exec #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [XLEN-1:0]  src_a,
  input  logic [XLEN-1:0]  src_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic             zero,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  logic             r_valid;
  logic [XLEN-1:0]  r_result;
  logic             r_zero;
  logic [TAG_W-1:0] r_tag;

  logic [SHW-1:0]   w_shamt;
  logic [XLEN-1:0]  w_alu;
  logic             w_in_ready;
  logic             w_accept;

  assign w_shamt  = src_b[SHW-1:0];
  assign w_accept = in_valid && w_in_ready;

  // Single-cycle result; in the serial build shifts only land here with shamt=0
  always_comb begin
    w_alu = '0;
    case (alu_ctrl)
      OP_ADD:  w_alu = src_a + src_b;
      OP_SUB:  w_alu = src_a - src_b;
      OP_AND:  w_alu = src_a & src_b;
      OP_OR:   w_alu = src_a | src_b;
      OP_XOR:  w_alu = src_a ^ src_b;
      OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, (src_a < src_b)};
`ifdef FAST_SHIFT_EN
      OP_SLL:  w_alu = src_a << w_shamt;
      OP_SRL:  w_alu = src_a >> w_shamt;
      OP_SRA:  w_alu = $unsigned($signed(src_a) >>> w_shamt);
`else
      OP_SLL, OP_SRL, OP_SRA: w_alu = src_a;
`endif
      default: w_alu = '0;
    endcase
  end

`ifdef FAST_SHIFT_EN

  assign w_in_ready = (!r_valid || out_ready) && !flush;
  assign busy       = 1'b0;

  // Output register: load on accept, drop on consume, clear valid on flush
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_tag    <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_result <= w_alu;
      r_zero   <= (w_alu == '0);
      r_tag    <= in_tag;
      r_valid  <= 1'b1;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

`else

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_sh;
  logic [SHW-1:0]  r_cnt;
  logic [3:0]      r_sh_op;
  logic [XLEN-1:0] w_sh_step;
  logic            w_is_shift;

  assign w_is_shift = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
  assign w_in_ready = (r_state == S_IDLE) && (!r_valid || out_ready) && !flush;
  assign busy       = (r_state == S_SHIFT);

  // One-bit shift step; SRA replicates the sign bit
  always_comb begin
    w_sh_step = r_sh >> 1;
    case (r_sh_op)
      OP_SLL:  w_sh_step = r_sh << 1;
      OP_SRA:  w_sh_step = {r_sh[XLEN-1], r_sh[XLEN-1:1]};
      default: w_sh_step = r_sh >> 1;
    endcase
  end

  // Control FSM plus output register; flush drops any in-flight shift
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_tag    <= '0;
      r_sh     <= '0;
      r_cnt    <= '0;
      r_sh_op  <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
    end else begin
      if (r_valid && out_ready) r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // Tag loads now; out_tag is don't-care until the shift finishes
            r_tag <= in_tag;
            if (w_is_shift && (w_shamt != '0)) begin
              r_sh    <= src_a;
              r_cnt   <= w_shamt;
              r_sh_op <= alu_ctrl;
              r_valid <= 1'b0;
              r_state <= S_SHIFT;
            end else begin
              r_result <= w_alu;
              r_zero   <= (w_alu == '0);
              r_valid  <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          r_sh  <= w_sh_step;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == SHW'(1)) begin
            r_result <= w_sh_step;
            r_zero   <= (w_sh_step == '0);
            r_valid  <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`endif

  assign in_ready  = w_in_ready;
  assign out_valid = r_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign out_tag   = r_tag;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed vectors with literal expectations, plus a per-cycle
// compare against a behavioural model (op semantics + latency countdown).
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_ctrl = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic [4:0]  out_tag;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  alu_exec #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .alu_ctrl(alu_ctrl),
    .src_a(src_a), .src_b(src_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // Reference semantics of each op
  function automatic logic [31:0] model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned s;
    s = b[4:0];
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: return a << s;
      4'd8: return a >> s;
      4'd9: return $unsigned($signed(a) >>> s);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [31:0] b);
`ifdef FAST_SHIFT_EN
    return 0;
`else
    if ((op == 4'd7 || op == 4'd8 || op == 4'd9) && b[4:0] != 5'd0) return int'(b[4:0]);
    return 0;
`endif
  endfunction

  // Model state: current output plus one pending serial op
  logic        m_valid = 1'b0;
  logic [31:0] m_res = '0;
  logic [4:0]  m_tag = '0;
  logic        m_pend = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_pres = '0;
  logic [4:0]  m_ptag = '0;
  logic        m_rdy;

  // Compare process: check outputs, then advance model across the coming edge
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_zero", zero, 1);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_busy", busy, 0);
      m_valid = 1'b0;
      m_pend  = 1'b0;
    end else begin
      chk("mdl_out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("mdl_result", result, m_res);
        chk("mdl_zero", zero, (m_res == 32'd0));
        chk("mdl_tag", out_tag, m_tag);
      end
      chk("mdl_busy", busy, m_pend);
      m_rdy = !m_pend && (!m_valid || out_ready) && !flush;
      chk("mdl_in_ready", in_ready, m_rdy);
      if (flush) begin
        m_valid = 1'b0;
        m_pend  = 1'b0;
      end else begin
        if (m_valid && out_ready) m_valid = 1'b0;
        if (m_pend) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_pend  = 1'b0;
            m_valid = 1'b1;
            m_res   = m_pres;
            m_tag   = m_ptag;
          end
        end else if (in_valid && m_rdy) begin
          if (model_lat(alu_ctrl, src_b) == 0) begin
            m_valid = 1'b1;
            m_res   = model_op(alu_ctrl, src_a, src_b);
            m_tag   = in_tag;
          end else begin
            m_pend = 1'b1;
            m_cnt  = model_lat(alu_ctrl, src_b);
            m_pres = model_op(alu_ctrl, src_a, src_b);
            m_ptag = in_tag;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op and hold it until accepted; returns just after the accept edge
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    bit done;
    done = 1'b0;
    alu_ctrl = op; src_a = a; src_b = b; in_tag = t; in_valid = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) chk("issue_timeout", 0, 1);
  endtask

  // Latency-1 result expected right after the accept edge
  task automatic expect_now(input string nm, input logic [31:0] r, input logic [4:0] t);
    @(negedge clk);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_result"}, result, r);
    chk({nm, "_zero"}, zero, (r == 32'd0));
    chk({nm, "_tag"}, out_tag, t);
    tick();
  endtask

  // Any-latency vector: wait (bounded) for out_valid, then check
  task automatic run_vec(input string nm, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r);
    bit seen;
    seen = 1'b0;
    issue(op, a, b, 5'd9);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else tick();
    end
    chk({nm, "_seen"}, seen, 1);
    chk({nm, "_result"}, result, r);
    chk({nm, "_zero"}, zero, (r == 32'd0));
    tick();
  endtask

  initial begin
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // 1. ADD / SUB
    issue(4'd0, 32'd5, 32'd7, 5'd3);
    expect_now("add", 32'd12, 5'd3);
    issue(4'd1, 32'd9, 32'd9, 5'd4);
    expect_now("sub", 32'd0, 5'd4);

    // 2. SLT / SLTU / XOR
    issue(4'd5, 32'hFFFF_FFFF, 32'd1, 5'd5);
    expect_now("slt", 32'd1, 5'd5);
    issue(4'd6, 32'hFFFF_FFFF, 32'd1, 5'd6);
    expect_now("sltu", 32'd0, 5'd6);
    issue(4'd4, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd7);
    expect_now("xor", 32'h0F0F_F0F0, 5'd7);

    // 3. SRA by 4
    issue(4'd9, 32'h8000_0000, 32'd4, 5'd8);
`ifdef FAST_SHIFT_EN
    expect_now("sra", 32'hF800_0000, 5'd8);
`else
    repeat (4) begin
      @(negedge clk);
      chk("sra_busy", busy, 1);
      chk("sra_in_ready", in_ready, 0);
      chk("sra_early_valid", out_valid, 0);
    end
    expect_now("sra", 32'hF800_0000, 5'd8);
`endif

    // Misc vectors and boundaries
    run_vec("and", 4'd2, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);
    run_vec("or", 4'd3, 32'hFF00_0000, 32'h0000_00FF, 32'hFF00_00FF);
    run_vec("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    run_vec("sub_wrap", 4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF);
    run_vec("sll0", 4'd7, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234);
    run_vec("sll2", 4'd7, 32'd3, 32'd2, 32'd12);
    run_vec("srl3", 4'd8, 32'h8000_0000, 32'd3, 32'h1000_0000);
    run_vec("slt_pos", 4'd5, 32'd1, 32'hFFFF_FFFF, 32'd0);
    run_vec("undef", 4'd15, 32'd5, 32'd6, 32'd0);

    // Back-to-back 1-cycle ops
    issue(4'd0, 32'd1, 32'd0, 5'd1);
    issue(4'd0, 32'd2, 32'd0, 5'd2);
    issue(4'd0, 32'd3, 32'd0, 5'd3);
    expect_now("b2b", 32'd3, 5'd3);

    // 4. Backpressure
    out_ready = 1'b0;
    issue(4'd0, 32'd1, 32'd1, 5'd1);
    alu_ctrl = 4'd0; src_a = 32'd2; src_b = 32'd3; in_tag = 5'd2; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_result", result, 32'd2);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    expect_now("bp_second", 32'd5, 5'd2);

    // 5. Flush during SLL; flush also beats a simultaneous in_valid
    issue(4'd7, 32'd1, 32'd20, 5'd7);
    flush = 1'b1;
    alu_ctrl = 4'd1; src_a = 32'd9; src_b = 32'd9; in_tag = 5'd11; in_valid = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", out_valid, 0);
    chk("flush_busy", busy, 0);
    chk("flush_in_ready_after", in_ready, 1);
    tick();
    issue(4'd0, 32'd3, 32'd4, 5'd12);
    expect_now("post_flush", 32'd7, 5'd12);

    // 6. Async reset mid-SRL
    issue(4'd8, 32'hFFFF_FFFF, 32'd31, 5'd13);
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_result", result, 0);
    chk("arst_zero", zero, 1);
    chk("arst_busy", busy, 0);
    tick();
    reset_n = 1'b1;
    tick();
    issue(4'd0, 32'd1, 32'd2, 5'd14);
    expect_now("post_rst", 32'd3, 5'd14);
    issue(4'hC, 32'd5, 32'd6, 5'd15);
    expect_now("undef_c", 32'd0, 5'd15);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
